// File: rtl/rev_order_reader.sv
// Writes a block of samples to an external 1-cycle-read RAM, then replays it last-first.
// First output is two edges after the closing write; m_ready low holds the output FIFO head stable and stops reads.
module rev_order_reader #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 13,
  parameter int MAX_LEN = 6147
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_rptr;
  logic              r_rd_done;
  logic              r_infl;
  logic              r_infl_last;
  logic              r_ovf;
  logic [DATA_W-1:0] r_fdat [2];
  logic [1:0]        r_flast;
  logic              r_rd_idx;
  logic              r_wr_idx;
  logic [1:0]        r_fcnt;

  logic w_wr_hs;
  logic w_at_max;
  logic w_blk_end;
  logic w_pop;
  logic w_pop_last;
  logic w_issue;

  assign w_wr_hs    = s_valid & s_ready;
  assign w_at_max   = (r_wcnt == ADDR_W'(MAX_LEN - 1));
  assign w_blk_end  = w_wr_hs & (s_last | w_at_max);

  assign m_valid    = (r_fcnt != 2'd0);
  assign m_data     = m_valid ? r_fdat[r_rd_idx] : '0;
  assign m_last     = m_valid & r_flast[r_rd_idx];
  assign w_pop      = m_valid & m_ready;
  assign w_pop_last = w_pop & m_last;

  // Counting the slot freed by a same-cycle pop keeps the stream bubble-free with only two entries.
  assign w_issue = (r_state == READ) & ~r_rd_done &
                   (((r_fcnt + {1'b0, r_infl}) < 2'd2) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = r_wcnt;
    ram_di      = '0;
    busy        = (r_state != IDLE);
    ovf         = r_ovf;
    case (r_state)
      IDLE, WRITE: begin
        s_ready = ~rst;
        ram_we  = w_wr_hs;
        ram_di  = w_wr_hs ? s_data : '0;
        if (w_blk_end) begin
          w_state_nxt = READ;
        end else if (w_wr_hs) begin
          w_state_nxt = WRITE;
        end
      end
      READ: begin
        ram_addr = r_rptr;
        if (w_pop_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt      <= '0;
      r_rptr      <= '0;
      r_rd_done   <= 1'b0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_ovf       <= 1'b0;
      r_fdat[0]   <= '0;
      r_fdat[1]   <= '0;
      r_flast     <= '0;
      r_rd_idx    <= 1'b0;
      r_wr_idx    <= 1'b0;
      r_fcnt      <= '0;
    end else begin
      if (w_wr_hs) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (r_state == IDLE) begin
          r_ovf <= 1'b0;
        end
        if (w_blk_end) begin
          r_wcnt    <= '0;
          r_rptr    <= r_wcnt;
          r_rd_done <= 1'b0;
          if (!s_last) begin
            r_ovf <= 1'b1;
          end
        end
      end

      r_infl <= w_issue;
      if (w_issue) begin
        r_infl_last <= (r_rptr == '0);
        if (r_rptr == '0) begin
          r_rd_done <= 1'b1;
        end else begin
          r_rptr <= r_rptr - 1'b1;
        end
      end

      if (r_infl) begin
        r_fdat[r_wr_idx]  <= ram_dout;
        r_flast[r_wr_idx] <= r_infl_last;
        r_wr_idx          <= ~r_wr_idx;
      end
      if (w_pop) begin
        r_rd_idx <= ~r_rd_idx;
      end
      r_fcnt <= r_fcnt + {1'b0, r_infl} - {1'b0, w_pop};
      if (w_pop_last) begin
        r_rd_idx <= 1'b0;
        r_wr_idx <= 1'b0;
        r_fcnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rev_order_reader.sv
// Directed bench: instance a uses the full-size block limit, instance b a limit of 8 for truncation.
module tb_rev_order_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_valid, s_last, m_ready, sel;
  logic [15:0] s_data;

  logic        a_s_ready, a_m_valid, a_m_last, a_ram_we, a_busy, a_ovf;
  logic [15:0] a_m_data, a_ram_di, a_ram_dout;
  logic [12:0] a_ram_addr;
  logic        b_s_ready, b_m_valid, b_m_last, b_ram_we, b_busy, b_ovf;
  logic [15:0] b_m_data, b_ram_di, b_ram_dout;
  logic [12:0] b_ram_addr;

  rev_order_reader u_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
    .m_last(a_m_last), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_di(a_ram_di),
    .ram_dout(a_ram_dout), .busy(a_busy), .ovf(a_ovf)
  );

  rev_order_reader #(.MAX_LEN(8)) u_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
    .m_last(b_m_last), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_di(b_ram_di),
    .ram_dout(b_ram_dout), .busy(b_busy), .ovf(b_ovf)
  );

  logic [15:0] a_mem [8192];
  logic [15:0] b_mem [8192];
  int a_we_n = 0;
  int b_we_n = 0;

  always @(posedge clk) begin
    if (a_ram_we) a_mem[a_ram_addr] <= a_ram_di;
    a_ram_dout <= a_mem[a_ram_addr];
    if (a_ram_we) a_we_n <= a_we_n + 1;
    if (b_ram_we) b_mem[b_ram_addr] <= b_ram_di;
    b_ram_dout <= b_mem[b_ram_addr];
    if (b_ram_we) b_we_n <= b_we_n + 1;
  end

  logic        o_s_ready, o_m_valid, o_m_last, o_ram_we, o_busy, o_ovf;
  logic [15:0] o_m_data;
  logic [12:0] o_ram_addr;

  always_comb begin
    o_s_ready  = sel ? b_s_ready  : a_s_ready;
    o_m_valid  = sel ? b_m_valid  : a_m_valid;
    o_m_last   = sel ? b_m_last   : a_m_last;
    o_m_data   = sel ? b_m_data   : a_m_data;
    o_ram_we   = sel ? b_ram_we   : a_ram_we;
    o_ram_addr = sel ? b_ram_addr : a_ram_addr;
    o_busy     = sel ? b_busy     : a_busy;
    o_ovf      = sel ? b_ovf      : a_ovf;
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] smp [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offers n samples from smp; stops early when the selected instance refuses one.
  task automatic send(input int n, input bit lastf, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = smp[i];
      s_last  = lastf && (i == n - 1);
      #1;
      if (!o_s_ready) break;
      chk("wr_we", o_ram_we, 1);
      chk("wr_addr", o_ram_addr, i);
      chk("wr_di", sel ? b_ram_di : a_ram_di, smp[i]);
      acc++;
      cyc();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  // Expects smp[n-1] down to smp[0]; mode 1 stalls with a fixed m_ready pattern.
  task automatic recv(input int n, input int mode, input int stop_after,
                      output int lat, output int bub);
    logic [15:0] pat;
    logic [15:0] hd;
    logic        hl;
    bit          hold, seen, done;
    int          cn, got;
    pat = 16'hB274;
    hold = 0; seen = 0; done = 0; cn = 0; got = 0; lat = -1; bub = 0;
    hd = '0; hl = 1'b0;
    while (!done && cn < 4 * n + 40) begin
      m_ready = (mode == 0) ? 1'b1 : pat[cn % 16];
      #1;
      if (hold) begin
        chk("stall_valid", o_m_valid, 1);
        chk("stall_data", o_m_data, hd);
        chk("stall_last", o_m_last, hl);
      end
      if (o_m_valid && !seen) begin
        seen = 1;
        lat  = cn;
      end else if (!o_m_valid && seen && m_ready) begin
        bub++;
      end
      hold = o_m_valid && !m_ready;
      hd   = o_m_data;
      hl   = o_m_last;
      if (o_m_valid && m_ready) begin
        if (got < n) begin
          chk("rd_data", o_m_data, smp[n - 1 - got]);
          chk("rd_last", o_m_last, (got == n - 1));
        end
        got++;
        if (o_m_last || got == stop_after) done = 1;
      end
      cyc();
      cn++;
    end
    m_ready = 1'b0;
    chk("recv_done", done, 1);
    chk("beats", got, stop_after);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int acc, lat, bub, w0;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0; sel = 1'b0;
    cyc();
    cyc();
    chk("rst_s_ready", a_s_ready, 0);
    chk("rst_m_valid", a_m_valid, 0);
    chk("rst_m_data", a_m_data, 0);
    chk("rst_m_last", a_m_last, 0);
    chk("rst_ram_we", a_ram_we, 0);
    chk("rst_ram_addr", a_ram_addr, 0);
    chk("rst_ram_di", a_ram_di, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ovf", a_ovf, 0);
    rst = 1'b0;
    #1;
    chk("idle_s_ready", a_s_ready, 1);
    chk("idle_busy", a_busy, 0);

    // Five samples, continuous drain
    smp = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    w0 = a_we_n;
    send(5, 1, acc);
    chk("b5_acc", acc, 5);
    chk("b5_first_addr", a_ram_addr, 4);
    chk("b5_read_s_ready", a_s_ready, 0);
    chk("b5_read_busy", a_busy, 1);
    chk("b5_read_we", a_ram_we, 0);
    recv(5, 0, 5, lat, bub);
    chk("b5_latency", lat, 2);
    chk("b5_bubbles", bub, 0);
    chk("b5_we_cycles", a_we_n - w0, 5);
    chk("b5_end_busy", a_busy, 0);
    chk("b5_end_s_ready", a_s_ready, 1);

    // Same block under stalls
    send(5, 1, acc);
    chk("b5s_acc", acc, 5);
    recv(5, 1, 5, lat, bub);
    chk("b5s_end_busy", a_busy, 0);

    // Single-sample block
    smp = {16'hABCD};
    send(1, 1, acc);
    chk("b1_acc", acc, 1);
    chk("b1_addr", a_ram_addr, 0);
    recv(1, 0, 1, lat, bub);
    chk("b1_latency", lat, 2);
    chk("b1_end_busy", a_busy, 0);
    chk("b1_end_s_ready", a_s_ready, 1);

    // Reset after three beats of a ten-sample block
    smp.delete();
    for (int i = 0; i < 10; i++) smp.push_back(16'h0100 + 16'(i));
    send(10, 1, acc);
    recv(10, 0, 3, lat, bub);
    pulse_rst();
    chk("mid_rst_m_valid", a_m_valid, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_s_ready", a_s_ready, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mid_rst_quiet", a_m_valid, 0);
    end
    m_ready = 1'b0;
    smp = {16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04};
    send(4, 1, acc);
    chk("b4_acc", acc, 4);
    recv(4, 0, 4, lat, bub);
    chk("b4_end_busy", a_busy, 0);

    // Full-length block
    smp.delete();
    for (int i = 0; i < 6147; i++) smp.push_back(16'(i * 37 + 5));
    send(6147, 1, acc);
    chk("full_acc", acc, 6147);
    chk("full_first_addr", a_ram_addr, 6146);
    recv(6147, 0, 6147, lat, bub);
    chk("full_latency", lat, 2);
    chk("full_bubbles", bub, 0);
    chk("full_ovf", a_ovf, 0);

    // Truncation on the MAX_LEN=8 instance
    pulse_rst();
    sel = 1'b1;
    smp.delete();
    for (int i = 0; i < 10; i++) smp.push_back(16'h0011 * 16'(i + 1));
    w0 = b_we_n;
    send(10, 0, acc);
    chk("ovf_acc", acc, 8);
    chk("ovf_s_ready", b_s_ready, 0);
    chk("ovf_flag", b_ovf, 1);
    chk("ovf_we_cycles", b_we_n - w0, 8);
    chk("ovf_first_addr", b_ram_addr, 7);
    recv(8, 0, 8, lat, bub);
    chk("ovf_sticky", b_ovf, 1);
    chk("ovf_end_busy", b_busy, 0);
    smp = {16'h0055, 16'h0066};
    send(2, 1, acc);
    chk("ovf_cleared", b_ovf, 0);
    recv(2, 0, 2, lat, bub);
    sel = 1'b0;
    pulse_rst();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
